// File: rtl/retire_monitor.sv
// retire_monitor
//   Retire-stream watchdog and architectural-state dumper for the OoO core.
//   Counts retired instructions and RUN cycles (both saturating), raises a
//   sticky hang flag after TIMEOUT retire-free cycles, and a sticky halt flag
//   when a valid lane retires HALT_PC. A hang, a halt or dump_req in RUN starts
//   a walk of arch regs DUMP_FIRST..DUMP_LAST through the rename map and PRF.
//   Each walked register produces one (arch, preg, data) record.
//
//   Optional feature macro: RETIRE_MON_LANE_CHECK_EN
//     defined   : lane_err flags non-contiguous commit_valid seen in RUN
//     undefined : lane_err tied 0, no check logic
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   commit_valid/pc   per-lane retire valid and PC (lane i at [i*XLEN +: XLEN])
//   dump_req          one-cycle dump request (RUN only)
//   map_raddr/rdata   rename-map read port (data one cycle after address)
//   prf_raddr/rdata   PRF read port (data one cycle after address)
//   retired_cnt       total retired instructions
//   cycle_cnt         cycles spent in RUN
//   hang, halt_hit    sticky watchdog / halt flags
//   lane_err          sticky lane-contiguity error
//   dump_valid        one-cycle pulse per record; dump_arch/preg/data hold
//   dump_done         dump finished (held until reset)
//   busy              monitor not in RUN
module retire_monitor #(
    parameter int unsigned     COMMIT_W   = 2,
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     PREG_W     = 7,
    parameter int unsigned     TIMEOUT    = 1000,
    parameter logic [XLEN-1:0] HALT_PC    = 'h34,
    parameter int unsigned     DUMP_FIRST = 10,
    parameter int unsigned     DUMP_LAST  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [COMMIT_W-1:0]      commit_valid,
    input  logic [COMMIT_W*XLEN-1:0] commit_pc,
    input  logic                     dump_req,
    output logic [4:0]               map_raddr,
    input  logic [PREG_W-1:0]        map_rdata,
    output logic [PREG_W-1:0]        prf_raddr,
    input  logic [XLEN-1:0]          prf_rdata,
    output logic [31:0]              retired_cnt,
    output logic [31:0]              cycle_cnt,
    output logic                     hang,
    output logic                     halt_hit,
    output logic                     lane_err,
    output logic                     dump_valid,
    output logic [4:0]               dump_arch,
    output logic [PREG_W-1:0]        dump_preg,
    output logic [XLEN-1:0]          dump_data,
    output logic                     dump_done,
    output logic                     busy
);

    typedef enum logic [2:0] {S_RUN, S_MAP, S_PRF, S_EMIT, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [31:0]        retired_cnt_q;
    logic [31:0]        cycle_cnt_q;
    logic [31:0]        idle_cnt;
    logic [4:0]         idx;
    logic [PREG_W-1:0]  preg;
    logic [2:0]         pop;
    logic               any_valid;
    logic               halt_set;
    logic               hang_set;
    logic               trigger;
    logic               last;
    logic [32:0]        ret_sum;

    always_comb begin
        pop       = '0;
        any_valid = 1'b0;
        halt_set  = 1'b0;
        for (int unsigned i = 0; i < COMMIT_W; i++) begin
            if (commit_valid[i]) begin
                pop       = pop + 3'd1;
                any_valid = 1'b1;
                if (commit_pc[i*XLEN +: XLEN] == HALT_PC) halt_set = 1'b1;
            end
        end
        // idle_cnt reaches TIMEOUT on this edge
        hang_set = !any_valid && (idle_cnt == 32'(TIMEOUT - 1));
        trigger  = hang_set | halt_set | dump_req;
    end

    assign last    = (idx == 5'(DUMP_LAST));
    assign ret_sum = {1'b0, retired_cnt_q} + {30'b0, pop};

    always_ff @(posedge clk) begin
        if (!reset) state <= S_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RUN:   if (trigger) state_nxt = S_MAP;
            S_MAP:   state_nxt = S_PRF;
            S_PRF:   state_nxt = S_EMIT;
            S_EMIT:  state_nxt = last ? S_DONE : S_MAP;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            retired_cnt_q <= '0;
            cycle_cnt_q   <= '0;
            idle_cnt      <= '0;
            hang          <= 1'b0;
            halt_hit      <= 1'b0;
            idx           <= 5'(DUMP_FIRST);
            preg          <= '0;
            map_raddr     <= '0;
            dump_valid    <= 1'b0;
            dump_arch     <= '0;
            dump_preg     <= '0;
            dump_data     <= '0;
        end else begin
            dump_valid <= 1'b0;
            unique case (state)
                S_RUN: begin
                    retired_cnt_q <= ret_sum[32] ? '1 : ret_sum[31:0];
                    if (cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + 32'd1;
                    if (any_valid)                       idle_cnt <= '0;
                    else if (idle_cnt != 32'(TIMEOUT))   idle_cnt <= idle_cnt + 32'd1;
                    hang     <= hang | hang_set;
                    halt_hit <= halt_hit | halt_set;
                    if (trigger) map_raddr <= idx;
                end
                S_PRF: preg <= map_rdata;
                S_EMIT: begin
                    // prf_rdata answers the address presented during PRF
                    dump_valid <= 1'b1;
                    dump_arch  <= idx;
                    dump_preg  <= preg;
                    dump_data  <= prf_rdata;
                    if (!last) begin
                        idx       <= idx + 5'd1;
                        map_raddr <= idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // PRF address follows map_rdata during PRF so the data lands in EMIT;
    // preg keeps it held afterwards.
    assign prf_raddr   = (state == S_PRF) ? map_rdata : preg;
    assign retired_cnt = retired_cnt_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign dump_done   = (state == S_DONE);
    assign busy        = (state != S_RUN);

`ifdef RETIRE_MON_LANE_CHECK_EN
    logic lane_gap;
    logic lane_err_q;

    always_comb begin
        lane_gap = 1'b0;
        for (int unsigned i = 1; i < COMMIT_W; i++) begin
            if (commit_valid[i] && !commit_valid[i-1]) lane_gap = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)              lane_err_q <= 1'b0;
        else if (state == S_RUN) lane_err_q <= lane_err_q | lane_gap;
    end

    assign lane_err = lane_err_q;
`else
    assign lane_err = 1'b0;
`endif

endmodule

// File: tb/tb_retire_monitor.sv
// tb_retire_monitor
//   Directed and random stimulus for retire_monitor with a behavioural model
//   of the counters, flags and dump records.
module tb_retire_monitor;
    localparam int unsigned CW = 2;
    localparam int unsigned XL = 32;
    localparam int unsigned PW = 7;
    localparam int unsigned TO = 8;
    localparam int unsigned DF = 10;
    localparam int unsigned DL = 11;
    localparam logic [31:0] HPC = 32'h34;
    localparam longint unsigned MAXC = 64'hFFFF_FFFF;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [CW-1:0]   commit_valid = '0;
    logic [CW*XL-1:0] commit_pc = '0;
    logic            dump_req = 1'b0;
    logic [4:0]      map_raddr;
    logic [PW-1:0]   map_rdata;
    logic [PW-1:0]   prf_raddr;
    logic [XL-1:0]   prf_rdata;
    logic [31:0]     retired_cnt, cycle_cnt;
    logic            hang, halt_hit, lane_err, dump_valid, dump_done, busy;
    logic [4:0]      dump_arch;
    logic [PW-1:0]   dump_preg;
    logic [XL-1:0]   dump_data;

    logic [PW-1:0]   map_mem [32];
    logic [XL-1:0]   prf_mem [128];

    int errors = 0;
    int checks = 0;

    longint unsigned m_ret, m_cyc;
    int unsigned     m_idle;
    logic            m_hang, m_halt, m_busy;

    retire_monitor #(
        .COMMIT_W(CW), .XLEN(XL), .PREG_W(PW), .TIMEOUT(TO),
        .HALT_PC(HPC), .DUMP_FIRST(DF), .DUMP_LAST(DL)
    ) dut (
        .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .dump_req(dump_req), .map_raddr(map_raddr), .map_rdata(map_rdata),
        .prf_raddr(prf_raddr), .prf_rdata(prf_rdata), .retired_cnt(retired_cnt),
        .cycle_cnt(cycle_cnt), .hang(hang), .halt_hit(halt_hit), .lane_err(lane_err),
        .dump_valid(dump_valid), .dump_arch(dump_arch), .dump_preg(dump_preg),
        .dump_data(dump_data), .dump_done(dump_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data appears the cycle after the address.
    always @(posedge clk) begin
        map_rdata <= map_mem[map_raddr];
        prf_rdata <= prf_mem[prf_raddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ret = 0; m_cyc = 0; m_idle = 0;
        m_hang = 1'b0; m_halt = 1'b0; m_busy = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; commit_valid = '0; commit_pc = '0; dump_req = 1'b0;
        tick(); tick();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".retired"}, retired_cnt, m_ret[31:0]);
        check({tag, ".cycle"},   cycle_cnt,   m_cyc[31:0]);
        check({tag, ".hang"},    32'(hang),     32'(m_hang));
        check({tag, ".halt"},    32'(halt_hit), 32'(m_halt));
        check({tag, ".busy"},    32'(busy),     32'(m_busy));
    endtask

    // One RUN-phase cycle: apply inputs, clock, advance the model, compare.
    task automatic step(input logic [CW-1:0] v, input logic [CW*XL-1:0] pc, input logic dr,
                        input string tag);
        int  n;
        logic hl, hs;
        commit_valid = v; commit_pc = pc; dump_req = dr;
        tick();
        dump_req = 1'b0;
        if (!m_busy) begin
            n  = $countones(v);
            hl = 1'b0;
            for (int i = 0; i < int'(CW); i++)
                if (v[i] && pc[i*XL +: XL] == HPC) hl = 1'b1;
            m_ret = m_ret + longint'(n);
            if (m_ret > MAXC) m_ret = MAXC;
            if (m_cyc < MAXC) m_cyc++;
            if (n != 0) m_idle = 0; else m_idle++;
            hs = (m_idle == TO);
            m_hang = m_hang | hs;
            m_halt = m_halt | hl;
            if (hs || hl || dr) m_busy = 1'b1;
        end
        check_counters(tag);
    endtask

    // Called on the cycle right after the trigger edge. Random commits and a
    // dump_req during EMIT must have no effect.
    task automatic check_dump(input string tag);
        logic [PW-1:0] p;
        for (int a = int'(DF); a <= int'(DL); a++) begin
            p = map_mem[a];
            check({tag, ".map_raddr"}, 32'(map_raddr), 32'(a));
            commit_valid = CW'($urandom); commit_pc = {HPC, HPC};
            tick();
            check({tag, ".prf_raddr"}, 32'(prf_raddr), 32'(p));
            check({tag, ".idle_pulse"}, 32'(dump_valid), 32'd0);
            tick();
            dump_req = 1'b1;
            check({tag, ".idle_pulse"}, 32'(dump_valid), 32'd0);
            tick();
            dump_req = 1'b0;
            check({tag, ".dump_valid"}, 32'(dump_valid), 32'd1);
            check({tag, ".dump_arch"},  32'(dump_arch),  32'(a));
            check({tag, ".dump_preg"},  32'(dump_preg),  32'(p));
            check({tag, ".dump_data"},  dump_data,       prf_mem[p]);
            check({tag, ".dump_done"},  32'(dump_done),  32'(a == int'(DL)));
        end
        commit_valid = '0;
        tick();
        check({tag, ".pulse_end"}, 32'(dump_valid), 32'd0);
        check({tag, ".done_hold"}, 32'(dump_done),  32'd1);
        check({tag, ".arch_hold"}, 32'(dump_arch),  32'(DL));
        check_counters({tag, ".frozen"});
    endtask

    initial begin
        logic [CW-1:0]    v;
        logic [CW*XL-1:0] pc;
        logic             dr;
        int               burst;

        for (int i = 0; i < 32; i++)  map_mem[i] = PW'($urandom);
        for (int i = 0; i < 128; i++) prf_mem[i] = $urandom;
        map_mem[10] = 7'd7;  map_mem[11] = 7'd40;
        prf_mem[7]  = 32'd5; prf_mem[40] = 32'hFFFF_FFFF;

        // Reset state
        do_reset();
        check_counters("reset");
        check("reset.lane_err",  32'(lane_err),   32'd0);
        check("reset.dvalid",    32'(dump_valid), 32'd0);
        check("reset.done",      32'(dump_done),  32'd0);
        check("reset.map_raddr", 32'(map_raddr),  32'd0);
        check("reset.prf_raddr", 32'(prf_raddr),  32'd0);
        check("reset.dump_data", dump_data,       32'd0);

        // Count: 5 x 2'b11 then 3 x 2'b01 -> 13 retired, 8 cycles
        for (int i = 0; i < 5; i++) step(2'b11, '0, 1'b0, "count");
        for (int i = 0; i < 3; i++) step(2'b01, '0, 1'b0, "count");
        check("count.retired13", retired_cnt, 32'd13);
        check("count.cycle8",    cycle_cnt,   32'd8);

        // Hang after 8 idle edges, then fixed dump data records
        do_reset();
        for (int i = 0; i < 7; i++) step('0, '0, 1'b0, "idle");
        check("hang.before", 32'(hang), 32'd0);
        step('0, '0, 1'b0, "hang");
        check("hang.set", 32'(hang), 32'd1);
        check_dump("hangdump");

        // Halt on lane1; an invalid lane carrying HALT_PC is ignored first
        do_reset();
        step(2'b01, {HPC, 32'h10}, 1'b0, "halt_inv");
        check("halt.inv_lane", 32'(halt_hit), 32'd0);
        step(2'b11, {HPC, 32'h30}, 1'b0, "halt");
        check("halt.retired", retired_cnt, 32'd3);
        check_dump("haltdump");

        // dump_req trigger, then reset in the PRF cycle aborts the dump
        do_reset();
        step(2'b11, '0, 1'b0, "dreq");
        step('0, '0, 1'b1, "dreq_trig");
        tick();
        check("abort.in_prf", 32'(prf_raddr), 32'(map_mem[10]));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        check_counters("abort");
        check("abort.map_raddr", 32'(map_raddr),  32'd0);
        check("abort.prf_raddr", 32'(prf_raddr),  32'd0);
        check("abort.dump_preg", 32'(dump_preg),  32'd0);
        check("abort.done",      32'(dump_done),  32'd0);
        for (int i = 0; i < 5; i++) begin
            step('0, '0, 1'b0, "after_abort");
            check("abort.no_pulse", 32'(dump_valid), 32'd0);
        end

        // Saturation of retired_cnt
        do_reset();
        dut.retired_cnt_q = 32'hFFFF_FFFE;
        m_ret = 64'hFFFF_FFFE;
        step(2'b11, '0, 1'b0, "sat");
        step(2'b01, '0, 1'b0, "sat");
        check("sat.max", retired_cnt, 32'hFFFF_FFFF);

        // Lane contiguity
        do_reset();
        step(2'b10, '0, 1'b0, "lane");
`ifdef RETIRE_MON_LANE_CHECK_EN
        check("lane.err", 32'(lane_err), 32'd1);
`else
        check("lane.err", 32'(lane_err), 32'd0);
`endif

        // Random retire stream against the model
        do_reset();
        burst = 0;
        for (int r = 0; r < 1500; r++) begin
            if (burst == 0 && $urandom_range(0, 49) == 0) burst = int'($urandom_range(4, 10));
            if (burst > 0) begin v = '0; burst--; end
            else v = CW'($urandom);
            for (int i = 0; i < int'(CW); i++)
                pc[i*XL +: XL] = ($urandom_range(0, 39) == 0) ? HPC : $urandom;
            dr = ($urandom_range(0, 59) == 0);
            step(v, pc, dr, "rand");
            if (m_busy) begin
                check_dump("randdump");
                map_mem[10] = PW'($urandom); map_mem[11] = PW'($urandom);
                prf_mem[map_mem[10]] = $urandom; prf_mem[map_mem[11]] = $urandom;
                do_reset();
                burst = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
